// File: rtl/lcd_pkg.sv
// Shared constants and helpers for the LCD pixel pipeline.
// Holds arbiter state encodings and the default pixel data width.
package lcd_pkg;

    localparam int LCD_DATA_WIDTH = 32;

    localparam logic [1:0] ARB_IDLE   = 2'd0;
    localparam logic [1:0] ARB_GRANT0 = 2'd1;
    localparam logic [1:0] ARB_GRANT1 = 2'd2;

    // Returns 1 when requester 1 should win an idle-state arbitration.
    function automatic logic rr_pick_req1(
        input logic valid0,
        input logic valid1,
        input logic last_served
    );
        return valid1 && (!valid0 || !last_served);
    endfunction

endpackage

// File: rtl/fifo_write_arbiter.sv
// Burst-locked round-robin arbiter sharing the LCD pixel FIFO write port
// between the command path (req0) and the framebuffer fill path (req1).
module fifo_write_arbiter
    import lcd_pkg::*;
#(
    parameter int DATA_WIDTH = LCD_DATA_WIDTH,
    parameter int MAX_BURST  = 16
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_req0Valid,
    input  logic [DATA_WIDTH-1:0] i_req0Data,
    input  logic                  i_req0Last,
    output logic                  o_req0Ready,
    input  logic                  i_req1Valid,
    input  logic [DATA_WIDTH-1:0] i_req1Data,
    input  logic                  i_req1Last,
    output logic                  o_req1Ready,
    output logic                  o_fifoWriteEnable,
    output logic [DATA_WIDTH-1:0] o_fifoWriteData,
    input  logic                  i_fifoFull,
    output logic [1:0]            o_grant
);

    localparam logic [7:0] BURST_FINAL = 8'(MAX_BURST - 1);

    logic [1:0] state;
    logic [1:0] state_next;
    logic [7:0] beat_count;
    logic       last_served;

    logic granted0;
    logic granted1;
    logic accept0;
    logic accept1;
    logic accept;
    logic burst_last;
    logic burst_end;

    assign granted0 = (state == ARB_GRANT0);
    assign granted1 = (state == ARB_GRANT1);

    assign o_req0Ready = granted0 && !i_fifoFull;
    assign o_req1Ready = granted1 && !i_fifoFull;

    assign accept0 = i_req0Valid && o_req0Ready;
    assign accept1 = i_req1Valid && o_req1Ready;
    assign accept  = accept0 || accept1;

    assign burst_last = granted1 ? i_req1Last : i_req0Last;

    // A burst ends on its last beat or when the beat cap is reached.
    assign burst_end = accept && (burst_last || (beat_count == BURST_FINAL));

    assign o_fifoWriteEnable = accept;
    assign o_grant           = {granted1, granted0};

    always_comb begin
        o_fifoWriteData = '0;
        if (granted0) begin
            o_fifoWriteData = i_req0Data;
        end else if (granted1) begin
            o_fifoWriteData = i_req1Data;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ARB_IDLE: begin
                if (i_req0Valid || i_req1Valid) begin
                    state_next = rr_pick_req1(i_req0Valid, i_req1Valid, last_served)
                               ? ARB_GRANT1 : ARB_GRANT0;
                end
            end
            ARB_GRANT0: begin
                if (burst_end) begin
                    state_next = i_req1Valid ? ARB_GRANT1 : ARB_IDLE;
                end
            end
            ARB_GRANT1: begin
                if (burst_end) begin
                    state_next = i_req0Valid ? ARB_GRANT0 : ARB_IDLE;
                end
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state       <= ARB_IDLE;
            beat_count  <= 8'd0;
            last_served <= 1'b1;
        end else begin
            state <= state_next;
            if (burst_end) begin
                beat_count  <= 8'd0;
                last_served <= granted1;
            end else if (accept) begin
                beat_count <= beat_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter: directed scenarios plus a
// randomized phase checked against per-requester queues and burst rules.
module tb_fifo_write_arbiter;

    localparam int DW = 32;
    localparam int MB = 16;

    typedef struct packed {
        logic          l;
        logic [DW-1:0] d;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          v0, l0, r0;
    logic          v1, l1, r1;
    logic [DW-1:0] d0, d1;
    logic          we;
    logic [DW-1:0] wd;
    logic          full;
    logic [1:0]    grant;

    beat_t         q0[$];
    beat_t         q1[$];
    logic [DW-1:0] exp0[$];
    logic [DW-1:0] exp1[$];

    int checks = 0;
    int errors = 0;
    bit gap_en = 1'b0;

    fifo_write_arbiter #(.DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .i_clock           (clk),
        .i_reset           (rst),
        .i_req0Valid       (v0),
        .i_req0Data        (d0),
        .i_req0Last        (l0),
        .o_req0Ready       (r0),
        .i_req1Valid       (v1),
        .i_req1Data        (d1),
        .i_req1Last        (l1),
        .o_req1Ready       (r1),
        .o_fifoWriteEnable (we),
        .o_fifoWriteData   (wd),
        .i_fifoFull        (full),
        .o_grant           (grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic push0(input logic [DW-1:0] d, input logic l);
        beat_t b;
        b.d = d;
        b.l = l;
        q0.push_back(b);
    endtask

    task automatic push1(input logic [DW-1:0] d, input logic l);
        beat_t b;
        b.d = d;
        b.l = l;
        q1.push_back(b);
    endtask

    task automatic clear_all();
        q0.delete();
        q1.delete();
        exp0.delete();
        exp1.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || v0 || v1) && n < limit) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= limit) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d required<%0d", n, limit);
        end
    endtask

    // Requester drivers: present queued beats, hold until accepted.
    initial begin
        bit a0;
        bit a1;
        v0 = 1'b0; d0 = '0; l0 = 1'b0;
        v1 = 1'b0; d1 = '0; l1 = 1'b0;
        forever begin
            @(negedge clk);
            a0 = v0 && r0;
            a1 = v1 && r1;
            @(posedge clk);
            #1;
            if (rst) begin
                v0 = 1'b0;
                v1 = 1'b0;
            end else begin
                if (a0) void'(q0.pop_front());
                if (v0 && !a0) begin
                end else if (q0.size() != 0 && !(gap_en && $urandom_range(3) == 0)) begin
                    v0 = 1'b1;
                    d0 = q0[0].d;
                    l0 = q0[0].l;
                    exp0.push_back(q0[0].d);
                end else begin
                    v0 = 1'b0;
                    d0 = $urandom;
                    l0 = 1'($urandom_range(1));
                end
                if (a1) void'(q1.pop_front());
                if (v1 && !a1) begin
                end else if (q1.size() != 0 && !(gap_en && $urandom_range(3) == 0)) begin
                    v1 = 1'b1;
                    d1 = q1[0].d;
                    l1 = q1[0].l;
                    exp1.push_back(q1[0].d);
                end else begin
                    v1 = 1'b0;
                    d1 = $urandom;
                    l1 = 1'($urandom_range(1));
                end
            end
        end
    end

    // Monitor: per-source ordering, burst integrity, round-robin handover.
    initial begin
        int owner;
        int beats;
        int must_next;
        bit s;
        logic [DW-1:0] e;
        owner = -1;
        beats = 0;
        must_next = -1;
        forever begin
            @(negedge clk);
            if (rst) begin
                owner = -1;
                beats = 0;
                must_next = -1;
            end else begin
                chk("we_handshake", 32'(we), 32'((v0 && r0) || (v1 && r1)));
                chk("single_ready", 32'(r0 && r1), 32'd0);
                if (full) chk("write_when_full", 32'({r0, r1, we}), 32'd0);
                if (grant == 2'b00) chk("idle_data", wd, 32'd0);
                if (we) begin
                    s = v1 && r1;
                    chk("grant_src", 32'(grant), s ? 32'd2 : 32'd1);
                    if (s ? (exp1.size() == 0) : (exp0.size() == 0)) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write src=%0d actual=%h required=none", s, wd);
                    end else begin
                        if (s) e = exp1.pop_front();
                        else e = exp0.pop_front();
                        chk(s ? "data_req1" : "data_req0", wd, e);
                    end
                    if (owner >= 0) begin
                        chk("burst_interleave", 32'(s), 32'(owner));
                    end else if (must_next >= 0) begin
                        chk("round_robin", 32'(s), 32'(must_next));
                    end
                    if (owner < 0) begin
                        owner = int'(s);
                        beats = 0;
                        must_next = -1;
                    end
                    beats++;
                    if ((s ? l1 : l0) || beats == MB) begin
                        owner = -1;
                        must_next = (s ? v0 : v1) ? int'(!s) : -1;
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        full = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_ready", 32'({r0, r1}), 32'd0);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_wd", wd, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single req0 burst of three beats.
        push0(32'h10, 1'b0);
        push0(32'h11, 1'b0);
        push0(32'h12, 1'b1);
        @(negedge clk);
        chk("t1_arb_latency", 32'({grant, we}), 32'd0);
        @(negedge clk);
        chk("t1_grant", 32'(grant), 32'd1);
        chk("t1_b0", wd, 32'h10);
        @(negedge clk);
        chk("t1_b1", wd, 32'h11);
        @(negedge clk);
        chk("t1_b2", wd, 32'h12);
        @(negedge clk);
        chk("t1_idle", 32'(grant), 32'd0);

        // Both valid from reset: req0 first, back-to-back handover.
        do_reset();
        push0(32'hA0, 1'b0);
        push0(32'hA1, 1'b1);
        push1(32'hB0, 1'b0);
        push1(32'hB1, 1'b1);
        @(negedge clk);
        chk("t2_idle", 32'(grant), 32'd0);
        @(negedge clk);
        chk("t2_g0", 32'(grant), 32'd1);
        chk("t2_a0", wd, 32'hA0);
        @(negedge clk);
        chk("t2_a1", wd, 32'hA1);
        @(negedge clk);
        chk("t2_g1", 32'(grant), 32'd2);
        chk("t2_b0", wd, 32'hB0);
        push0(32'hA2, 1'b1);
        @(negedge clk);
        chk("t2_b1", wd, 32'hB1);
        @(negedge clk);
        chk("t2_g0_again", 32'(grant), 32'd1);
        chk("t2_a2", wd, 32'hA2);
        @(negedge clk);
        chk("t2_end_idle", 32'(grant), 32'd0);

        // req1 long stream, capped at MB beats while req0 waits.
        for (int i = 0; i < 20; i++) push1(32'h300 + i, i == 19);
        @(negedge clk);
        push0(32'h3C0, 1'b1);
        for (int i = 0; i < MB; i++) begin
            @(negedge clk);
            chk("t3_grant1", 32'(grant), 32'd2);
            chk("t3_stream", wd, 32'h300 + i);
        end
        @(negedge clk);
        chk("t3_handover", 32'(grant), 32'd1);
        chk("t3_req0", wd, 32'h3C0);
        @(negedge clk);
        chk("t3_resume", wd, 32'h300 + MB);
        wait_drain(50);
        @(negedge clk);
        chk("t3_idle", 32'(grant), 32'd0);

        // FIFO full for five cycles mid-burst.
        push0(32'h40, 1'b0);
        push0(32'h41, 1'b0);
        push0(32'h42, 1'b0);
        push0(32'h43, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("t4_b0", wd, 32'h40);
        @(posedge clk);
        #2 full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_stall", 32'({r0, we}), 32'd0);
            chk("t4_lock", 32'(grant), 32'd1);
        end
        @(posedge clk);
        #2 full = 1'b0;
        @(negedge clk);
        chk("t4_b1", wd, 32'h41);
        @(negedge clk);
        chk("t4_b2", wd, 32'h42);
        @(negedge clk);
        chk("t4_b3", wd, 32'h43);
        @(negedge clk);
        chk("t4_idle", 32'(grant), 32'd0);

        // Async reset mid-burst, then a simultaneous request pair.
        for (int i = 0; i < 4; i++) push0(32'h50 + i, i == 3);
        @(negedge clk);
        @(negedge clk);
        chk("t5_b0", wd, 32'h50);
        @(negedge clk);
        chk("t5_b1", wd, 32'h51);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("t5_rst_grant", 32'(grant), 32'd0);
        chk("t5_rst_ready", 32'({r0, r1}), 32'd0);
        chk("t5_rst_we", 32'(we), 32'd0);
        chk("t5_rst_wd", wd, 32'd0);
        clear_all();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        push0(32'hD0, 1'b1);
        push1(32'hE0, 1'b1);
        @(negedge clk);
        chk("t5_idle", 32'(grant), 32'd0);
        @(negedge clk);
        chk("t5_first", 32'(grant), 32'd1);
        chk("t5_d0", wd, 32'hD0);
        @(negedge clk);
        chk("t5_second", 32'(grant), 32'd2);
        chk("t5_e0", wd, 32'hE0);
        @(negedge clk);
        chk("t5_end", 32'(grant), 32'd0);

        // Randomized traffic with random gaps and full back-pressure.
        gap_en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #2 full = ($urandom_range(3) == 0);
            @(negedge clk);
            if (q0.size() == 0 && $urandom_range(7) == 0) begin
                int n0;
                n0 = $urandom_range(24, 1);
                for (int i = 0; i < n0; i++) push0($urandom, i == n0 - 1);
            end
            if (q1.size() == 0 && $urandom_range(7) == 0) begin
                int n1;
                n1 = $urandom_range(24, 1);
                for (int i = 0; i < n1; i++) push1($urandom, i == n1 - 1);
            end
        end
        @(posedge clk);
        #2 full = 1'b0;
        wait_drain(1000);
        @(negedge clk);
        @(negedge clk);
        chk("rand_idle", 32'(grant), 32'd0);
        chk("rand_exp0_empty", 32'(exp0.size()), 32'd0);
        chk("rand_exp1_empty", 32'(exp1.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Shares the write port of the 32-bit LCD pixel FIFO between two requesters: requester 0 is the command/register path, requester 1 is the framebuffer fill path.
- Arbitration is round-robin at burst granularity. A grant is locked for the whole burst.
- Honours the FIFO full flag so no write is ever issued while full.
- Sits on the FIFO write-clock domain, directly in front of the FIFO input port.

Parameters:
- DATA_WIDTH, 32, width of requester and FIFO data.
- MAX_BURST, 16, maximum beats per grant before forced release (range 1..255).

Ports:
- i_clock  input  1  write-domain clock; all state updates on its rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_req0Valid  input  1  requester 0 has a beat to write.
- i_req0Data  input  DATA_WIDTH  requester 0 beat data.
- i_req0Last  input  1  beat is the final beat of requester 0's burst.
- o_req0Ready  output  1  requester 0 beat accepted this cycle when ANDed with i_req0Valid.
- i_req1Valid  input  1  requester 1 has a beat to write.
- i_req1Data  input  DATA_WIDTH  requester 1 beat data.
- i_req1Last  input  1  beat is the final beat of requester 1's burst.
- o_req1Ready  output  1  requester 1 beat accepted this cycle when ANDed with i_req1Valid.
- o_fifoWriteEnable  output  1  FIFO write strobe.
- o_fifoWriteData  output  DATA_WIDTH  FIFO write data.
- i_fifoFull  input  1  FIFO full flag, synchronous to i_clock.
- o_grant  output  2  one-hot current grant (bit0 = req0, bit1 = req1); 00 = idle.

Behaviour:
- State machine: IDLE, GRANT0, GRANT1. Registered state, 8-bit beat counter, 1-bit lastServed pointer.
- Reset (async, any time including mid-burst) sets:
  - state = IDLE, beat counter = 0, lastServed = 1 (so req0 wins the first tie);
  - o_grant = 00, o_req0Ready = o_req1Ready = 0, o_fifoWriteEnable = 0, o_fifoWriteData = 0.
  - Any partially written burst is abandoned; no recovery.
- IDLE decision (registered, 1-cycle arbitration latency):
  - only req0 valid -> GRANT0; only req1 valid -> GRANT1;
  - both valid -> the requester != lastServed;
  - neither valid -> stay IDLE.
  - No beats are accepted while in IDLE.
- In GRANTx:
  - o_reqxReady = !i_fifoFull; the other requester's ready = 0.
  - Accept = i_reqxValid && o_reqxReady.
- Write path is combinational, zero latency from accept:
  - o_fifoWriteEnable = accept;
  - o_fifoWriteData = granted requester's data while in GRANT0/GRANT1, else 0.
  - Guarantees no write when i_fifoFull = 1.
- Beat counter:
  - increments on each accept; cleared on every grant change.
- Burst end occurs on an accepted beat with i_reqxLast = 1, or when the accept makes the count reach MAX_BURST. On burst end:
  - lastServed <= x;
  - next state is GRANT(other) if the other requester is valid this cycle, else IDLE. This is a back-to-back handover with no idle cycle, and the new grant's ready is first asserted next cycle.
- Burst lock: the grant is held through cycles where i_reqxValid = 0 or i_fifoFull = 1; only burst end releases it.
- Requester rules:
  - data and last are held stable while valid && !ready;
  - valid is never dropped before acceptance.
- i_fifoFull rising in the same cycle as a last beat: the beat is not accepted, the grant is held, and the beat is retried when full deasserts.
- o_grant reflects the registered state: 01 in GRANT0, 10 in GRANT1, 00 in IDLE.

Decomposition:
- Shared package (lcd_pkg):
  - state encoding constants ARB_IDLE = 2'd0, ARB_GRANT0 = 2'd1, ARB_GRANT1 = 2'd2;
  - LCD_DATA_WIDTH = 32, used as the DATA_WIDTH default.
- Single module. No sub-module is warranted; the round-robin pick is a two-line expression.

Test Plan:
- Reset, then req0 sends a 3-beat burst 0x10, 0x11, 0x12 with last on 0x12, req1 idle -> o_grant = 01 one cycle after valid; FIFO receives 0x10, 0x11, 0x12 on 3 consecutive cycles; returns to IDLE.
- Both requesters valid from IDLE, each sending 2-beat bursts (req0 0xA0/0xA1, req1 0xB0/0xB1) -> writes in order A0, A1, B0, B1; handover has no idle cycle between A1 and B0 writes beyond the 1-cycle grant change; then A-burst next if req0 re-requests.
- req1 streams continuously with no last, MAX_BURST = 16, req0 waiting -> exactly 16 req1 beats are written, then the grant passes to req0.
- Grant to req0, i_fifoFull asserted for 5 cycles mid-burst -> o_req0Ready = 0 and o_fifoWriteEnable = 0 for those 5 cycles; beat data held; the burst resumes with no loss or duplication.
- Async reset asserted mid-burst (after 2 of 4 beats) between clock edges -> o_grant = 00, readies = 0 and write enable = 0 immediately; after release, req0 and req1 simultaneously valid -> req0 is granted first.
